// File: rtl/tsp_pkg.sv
// tsp_pkg: shared widths, FSM encodings and popcount helper for the decoder scheduler
package tsp_pkg;

    localparam int CITY_W = 6;
    localparam int NCITY  = 64;
    localparam int CNT_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAITB = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] popcount64(input logic [NCITY-1:0] m);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < NCITY; i++) s = s + CNT_W'(m[i]);
        return s;
    endfunction

endpackage

// File: rtl/pos_fifo.sv
// pos_fifo: synchronous FIFO with occupancy count; a pop frees a slot for a same-cycle push
module pos_fifo #(
    parameter int DEPTH = 64,
    parameter int W     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          w_wr, w_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    // storage array, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

    // pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + AW'(1);
            if (w_rd) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

endmodule

// File: rtl/decoder_sched.sv
// decoder_sched: round-robin sharing of one set-bit decoder between two requesters, positions streamed via FIFO
module decoder_sched
    import tsp_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int NREQ       = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NCITY-1:0]  i_req_mask0,
    input  logic [NCITY-1:0]  i_req_mask1,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_dec_start,
    output logic [NCITY-1:0]  o_dec_bit_position,
    input  logic              i_dec_idle,
    input  logic              i_dec_valid,
    input  logic [CITY_W-1:0] i_dec_position,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_id,
    output logic [CITY_W-1:0] o_out_position,
    output logic              o_out_last,
    output logic              o_done_valid,
    output logic              o_done_id,
    output logic [CNT_W-1:0]  o_done_count,
    output logic              o_busy,
    output logic              o_err
);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state, w_next;
    logic [NCITY-1:0]  r_mask;
    logic              r_id, r_rr, r_zero_done, r_err;
    logic [CNT_W-1:0]  r_pcnt, r_push_cnt;
    logic [CNT_W-1:0]  w_pc0, w_pc1, w_gpc;
    logic [FW-1:0]     w_count, w_free;
    logic [NREQ-1:0]   w_elig;
    logic              w_grant, w_gid, w_push, w_pop, w_full, w_empty, w_err, w_last;
    logic [7:0]        w_fifo_out;

    assign w_pc0   = popcount64(i_req_mask0);
    assign w_pc1   = popcount64(i_req_mask1);
    assign w_free  = FW'(FIFO_DEPTH) - w_count;
    assign w_elig  = {i_req_valid[1] && (w_free >= FW'(w_pc1)),
                      i_req_valid[0] && (w_free >= FW'(w_pc0))};
    assign w_gid   = w_elig[r_rr] ? r_rr : !r_rr;
    assign w_gpc   = w_gid ? w_pc1 : w_pc0;
    assign w_grant = (r_state == S_IDLE) && |w_elig;
    assign w_pop   = !w_empty && i_out_ready;
    assign w_last  = (r_push_cnt + CNT_W'(1)) == r_pcnt;
    assign w_push  = (r_state == S_SCAN) && i_dec_valid && (r_push_cnt < r_pcnt);
    assign w_err   = (i_dec_valid && (r_state != S_SCAN))
                   || (i_dec_valid && (r_state == S_SCAN) && (r_push_cnt >= r_pcnt))
                   || (w_push && w_full && !w_pop)
                   || ((r_state == S_DONE) && (r_push_cnt != r_pcnt));

    pos_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  ({r_id, w_last, i_dec_position}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // next-state and per-state outputs; zero-popcount grants never leave S_IDLE
    always_comb begin
        w_next      = r_state;
        o_req_ready = '0;
        o_req_ready[w_gid] = w_grant;
        o_dec_start = (r_state == S_START);
        case (r_state)
            S_IDLE:  w_next = (w_grant && (w_gpc != '0)) ? S_START : S_IDLE;
            S_START: w_next = S_WAITB;
            S_WAITB: w_next = i_dec_idle ? S_WAITB : S_SCAN;
            S_SCAN:  w_next = i_dec_idle ? S_DONE : S_SCAN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // job registers, arbitration pointer and sticky error
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_id        <= 1'b0;
            r_rr        <= 1'b0;
            r_zero_done <= 1'b0;
            r_err       <= 1'b0;
            r_pcnt      <= '0;
            r_push_cnt  <= '0;
        end else begin
            r_state     <= w_next;
            r_err       <= r_err | w_err;
            r_zero_done <= w_grant && (w_gpc == '0);
            if (w_grant) begin
                r_mask     <= w_gid ? i_req_mask1 : i_req_mask0;
                r_id       <= w_gid;
                r_pcnt     <= w_gpc;
                r_push_cnt <= '0;
            end else if ((r_state == S_SCAN) && i_dec_valid) begin
                r_push_cnt <= r_push_cnt + CNT_W'(1);
            end
            if (w_grant && (w_gpc == '0)) r_rr <= !w_gid;
            else if (r_state == S_DONE) r_rr <= !r_id;
        end
    end

    assign o_dec_bit_position = r_mask;
    assign o_out_valid    = !w_empty;
    assign o_out_id       = w_fifo_out[7];
    assign o_out_last     = w_fifo_out[6];
    assign o_out_position = w_fifo_out[5:0];
    assign o_done_valid   = (r_state == S_DONE) || r_zero_done;
    assign o_done_id      = o_done_valid ? r_id : 1'b0;
    assign o_done_count   = o_done_valid ? r_push_cnt : '0;
    assign o_busy         = (r_state != S_IDLE);
    assign o_err          = r_err;

endmodule
